arb_mux: RTL

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux_if.sv | 26 ++
 rtl/arb_mux.sv | 88 ++++++++
 2 files changed

// File: rtl/arb_mux_if.sv
// Channel-side and output-side handshake bundle for arb_mux.
// slave = the arbiter, master = whatever drives requests and consumes the output.
interface arb_mux_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
);
    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [CW-1:0]      out_chan;
    logic               out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/arb_mux.sv
// N-channel arbitrating mux with a single registered output stage.
// Round-robin (RR=1) or fixed lowest-index priority (RR=0).
module arb_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned RR    = 1
) (
    input  logic       clk,
    input  logic       rst,
    arb_mux_if.slave   bus
);
    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

    logic [CW-1:0]    ptr_q, ptr_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] od_q, od_d;
    logic [CW-1:0]    oc_q, oc_d;

    logic             load;
    logic             any_valid;
    logic [CW-1:0]    grant;
    logic [CW-1:0]    base;
    logic [N-1:0]     ready;
    int unsigned      idx;

    assign load = !ov_q || bus.out_ready;

    // Wrap-around search starting at the pointer; first requester found wins.
    always_comb begin
        base      = (RR != 0) ? ptr_q : '0;
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(base) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_valid && bus.in_valid[idx[CW-1:0]]) begin
                any_valid = 1'b1;
                grant     = idx[CW-1:0];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (!rst && load && any_valid) begin
            ready[grant] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        ov_d  = ov_q;
        od_d  = od_q;
        oc_d  = oc_q;
        if (load) begin
            ov_d = any_valid;
            if (any_valid) begin
                od_d = bus.in_data[32'(grant)*WIDTH +: WIDTH];
                oc_d = grant;
                if (RR != 0) begin
                    ptr_d = (grant == CW'(N - 1)) ? '0 : grant + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            ov_q  <= 1'b0;
            od_q  <= '0;
            oc_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            ov_q  <= ov_d;
            od_q  <= od_d;
            oc_q  <= oc_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_chan  = oc_q;
endmodule
